// File: rtl/line_buf_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// line_buf_scheduler_pkg
// Shared types and default constants for the line-buffer scheduler.
//   state_e     : scheduler FSM states
//   buf_sel_e   : which of the two line RAMs is meant
//   rd_kind_e   : how a returning read word is turned into an output word
//   DATA_WIDTH, WIDTH, HALF_HEIGHT : default geometry (pixel bits, pixels per
//   line, lines per field); ADDR_W / CNT_W size the address and pair counter.
// ---------------------------------------------------------------------------
package line_buf_scheduler_pkg;

  localparam int DATA_WIDTH  = 24;
  localparam int WIDTH       = 640;
  localparam int HALF_HEIGHT = 240;
  localparam int ADDR_W      = 10;
  localparam int CNT_W       = 10;
  localparam int SYM_W       = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_ORIG,
    S_AVER,
    S_TAIL_A,
    S_TAIL_B,
    S_ACK
  } state_e;

  typedef enum logic {
    buff0 = 1'b0,
    buff1 = 1'b1
  } buf_sel_e;

  typedef enum logic [1:0] {
    RK_OLD,
    RK_AVG,
    RK_NEW
  } rd_kind_e;

endpackage

// File: rtl/line_buf_scheduler_st_skid_buf.sv
// ---------------------------------------------------------------------------
// st_skid_buf
// Two-entry FIFO in front of the Avalon-ST source. Carries data plus
// start/end-of-packet flags. The producer only pushes when an entry is free
// (it uses 'count' for that), so there is no full/overflow handling here.
//   clock, reset                 : clock, synchronous active-high reset
//   in_valid/in_data/in_sop/in_eop : push side
//   out_valid/out_data/out_sop/out_eop/out_ready : pop side (ready latency 0)
//   count                        : current occupancy 0..2
// Outputs are forced to 0 while empty so they read 0 straight after reset.
// ---------------------------------------------------------------------------
module st_skid_buf #(
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sop,
  input  logic                  in_eop,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  input  logic                  out_ready,
  output logic [1:0]            count
);

  logic [DATA_WIDTH+1:0] mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic                  pop;
  logic [DATA_WIDTH+1:0] head;

  assign pop       = out_valid & out_ready;
  assign out_valid = (count != 2'd0);
  assign head      = mem[rd_ptr];
  assign out_data  = out_valid ? head[DATA_WIDTH-1:0] : '0;
  assign out_sop   = out_valid & head[DATA_WIDTH+1];
  assign out_eop   = out_valid & head[DATA_WIDTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (in_valid) wr_ptr <= ~wr_ptr;
      if (pop)      rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, in_valid} - {1'b0, pop};
    end
  end

  always_ff @(posedge clock) begin
    if (in_valid) mem[wr_ptr] <= {in_sop, in_eop, in_data};
  end

endmodule

// File: rtl/line_buf_scheduler.sv
// ---------------------------------------------------------------------------
// line_buf_scheduler
// Reads line pairs from two line RAMs and emits a progressive frame on an
// Avalon-ST source: per pair the older line unchanged, then the per-symbol
// average of both lines; the last pair of a field additionally repeats the
// newer line twice. The first pair of a frame is preceded by a header word.
//   clock, reset        : clock, synchronous active-high reset
//   ready_to_continue   : sink has a complete line pair in both buffers
//   aver_sent           : one-cycle pulse, older buffer may be overwritten
//   rd_addr, rd_en0/1   : shared RAM read address and per-RAM strobes
//   q0, q1              : RAM read data, valid one cycle after the strobe
//   dout_*              : Avalon-ST source, ready latency 0
// ---------------------------------------------------------------------------
module line_buf_scheduler
  import line_buf_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH  = line_buf_scheduler_pkg::DATA_WIDTH,
  parameter int WIDTH       = line_buf_scheduler_pkg::WIDTH,
  parameter int HALF_HEIGHT = line_buf_scheduler_pkg::HALF_HEIGHT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ready_to_continue,
  output logic                  aver_sent,
  output logic [ADDR_W-1:0]     rd_addr,
  output logic                  rd_en0,
  output logic                  rd_en1,
  input  logic [DATA_WIDTH-1:0] q0,
  input  logic [DATA_WIDTH-1:0] q1,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_startofpacket,
  output logic                  dout_endofpacket
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  LAST_PAIR = CNT_W'(HALF_HEIGHT - 2);

  function automatic logic [DATA_WIDTH-1:0] avg_word(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
    logic [SYM_W:0] sum;
    avg_word = '0;
    for (int i = 0; i < DATA_WIDTH / SYM_W; i++) begin
      sum = {1'b0, a[i*SYM_W +: SYM_W]} + {1'b0, b[i*SYM_W +: SYM_W]};
      avg_word[i*SYM_W +: SYM_W] = sum[SYM_W:1];
    end
  endfunction

  state_e          state;
  buf_sel_e        ob;
  logic [CNT_W-1:0] pair_cnt;
  logic            drain;

  logic            rd_vld_p0;
  rd_kind_e        rd_kind_p0;
  buf_sel_e        rd_ob_p0;
  logic            rd_eop_p0;

  logic [1:0]      sk_count;
  logic            pop;
  logic            hdr_push;
  logic [2:0]      occ_next;
  logic            rd_state;
  logic            issue;
  logic            last_addr;
  rd_kind_e        kind;
  buf_sel_e        sel;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] new_word;
  logic [DATA_WIDTH-1:0] ret_word;
  logic            push_valid;
  logic [DATA_WIDTH-1:0] push_data;

  assign pop       = dout_valid & dout_ready;
  assign last_addr = (rd_addr == LAST_ADDR);
  assign rd_state  = (state inside {S_HDR, S_ORIG, S_AVER, S_TAIL_A, S_TAIL_B}) && !drain;

  // The header only needs a free slot after this cycle's pop.
  assign hdr_push  = (state == S_HDR) && ((sk_count != 2'd2) || pop);

  // Occupancy after this edge; a read issued now lands one edge later, so it
  // is safe only if at least one slot is still free after this edge.
  assign occ_next  = 3'(sk_count) + 3'(rd_vld_p0) + 3'(hdr_push) - 3'(pop);
  assign issue     = !reset && rd_state && ((state != S_HDR) || hdr_push) && (occ_next < 3'd2);

  always_comb begin
    kind = RK_OLD;
    case (state)
      S_AVER:            kind = RK_AVG;
      S_TAIL_A, S_TAIL_B: kind = RK_NEW;
      default:           kind = RK_OLD;
    endcase
  end

  assign sel    = (kind == RK_OLD) ? ob : ((ob == buff0) ? buff1 : buff0);
  assign rd_en0 = issue && ((kind == RK_AVG) || (sel == buff0));
  assign rd_en1 = issue && ((kind == RK_AVG) || (sel == buff1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      ob        <= buff0;
      pair_cnt  <= '0;
      rd_addr   <= '0;
      drain     <= 1'b0;
      rd_vld_p0 <= 1'b0;
      aver_sent <= 1'b0;
    end else begin
      rd_vld_p0 <= issue;
      aver_sent <= 1'b0;
      if (issue) rd_addr <= last_addr ? '0 : rd_addr + 1'b1;
      case (state)
        S_IDLE: begin
          if (ready_to_continue) state <= (pair_cnt == '0) ? S_HDR : S_ORIG;
        end
        S_HDR: begin
          if (hdr_push) state <= S_ORIG;
        end
        S_ORIG: begin
          if (issue && last_addr) state <= S_AVER;
        end
        S_AVER, S_TAIL_B: begin
          // drain holds for the one cycle the last read needs to land.
          if (drain) begin
            drain     <= 1'b0;
            aver_sent <= 1'b1;
            state     <= S_ACK;
          end else if (issue && last_addr) begin
            if (state == S_AVER && pair_cnt == LAST_PAIR) state <= S_TAIL_A;
            else                                          drain <= 1'b1;
          end
        end
        S_TAIL_A: begin
          if (issue && last_addr) state <= S_TAIL_B;
        end
        S_ACK: begin
          ob       <= (ob == buff0) ? buff1 : buff0;
          pair_cnt <= (pair_cnt == LAST_PAIR) ? '0 : pair_cnt + 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---- stage p0: read tag travels with the outstanding RAM read ----
  always_ff @(posedge clock) begin
    rd_kind_p0 <= kind;
    rd_ob_p0   <= ob;
    rd_eop_p0  <= (state == S_TAIL_B) && last_addr;
  end

  // ---- stage p1: RAM data returns, output word formed and pushed ----
  assign old_word = (rd_ob_p0 == buff0) ? q0 : q1;
  assign new_word = (rd_ob_p0 == buff0) ? q1 : q0;

  always_comb begin
    ret_word = old_word;
    case (rd_kind_p0)
      RK_AVG:  ret_word = avg_word(q0, q1);
      RK_NEW:  ret_word = new_word;
      default: ret_word = old_word;
    endcase
  end

  assign push_valid = rd_vld_p0 | hdr_push;
  assign push_data  = hdr_push ? '0 : ret_word;

  st_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (push_valid),
    .in_data   (push_data),
    .in_sop    (hdr_push),
    .in_eop    (rd_vld_p0 & rd_eop_p0),
    .out_valid (dout_valid),
    .out_data  (dout_data),
    .out_sop   (dout_startofpacket),
    .out_eop   (dout_endofpacket),
    .out_ready (dout_ready),
    .count     (sk_count)
  );

endmodule

// File: tb/tb_line_buf_scheduler.sv
// ---------------------------------------------------------------------------
// tb_line_buf_scheduler
// Bench for line_buf_scheduler with WIDTH=4, HALF_HEIGHT=3. Line RAMs are
// modelled as arrays with one-cycle read latency; the expected word stream of
// each line pair is built from the buffer contents, the bench's own idea of
// which buffer is older, and the position of the pair in the field.
// ---------------------------------------------------------------------------
module tb_line_buf_scheduler;

  localparam int DW = 24;
  localparam int W  = 4;
  localparam int HH = 3;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
  } word_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ready_to_continue = 1'b0;
  logic          aver_sent;
  logic [9:0]    rd_addr;
  logic          rd_en0, rd_en1;
  logic [DW-1:0] q0 = '0;
  logic [DW-1:0] q1 = '0;
  logic [DW-1:0] dout_data;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
  logic          dout_sop, dout_eop;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mem0 [W];
  logic [DW-1:0] mem1 [W];
  int            model_ob   = 0;
  int            model_pair = 0;
  word_t         exp_q [$];

  line_buf_scheduler #(
    .DATA_WIDTH  (DW),
    .WIDTH       (W),
    .HALF_HEIGHT (HH)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .ready_to_continue  (ready_to_continue),
    .aver_sent          (aver_sent),
    .rd_addr            (rd_addr),
    .rd_en0             (rd_en0),
    .rd_en1             (rd_en1),
    .q0                 (q0),
    .q1                 (q1),
    .dout_data          (dout_data),
    .dout_valid         (dout_valid),
    .dout_ready         (dout_ready),
    .dout_startofpacket (dout_sop),
    .dout_endofpacket   (dout_eop)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (rd_en0) q0 <= mem0[rd_addr[1:0]];
    if (rd_en1) q1 <= mem1[rd_addr[1:0]];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] avg_model(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r = '0;
    for (int s = 0; s < DW / 8; s++) begin
      int sa = int'(a[s*8 +: 8]);
      int sb = int'(b[s*8 +: 8]);
      r[s*8 +: 8] = 8'((sa + sb) / 2);
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] line_word(input int which, input int i);
    return (which == 0) ? mem0[i] : mem1[i];
  endfunction

  task automatic build_expected();
    int nb = 1 - model_ob;
    exp_q.delete();
    if (model_pair == 0) exp_q.push_back('{sop: 1'b1, eop: 1'b0, data: '0});
    for (int i = 0; i < W; i++) exp_q.push_back('{sop: 1'b0, eop: 1'b0, data: line_word(model_ob, i)});
    for (int i = 0; i < W; i++) exp_q.push_back('{sop: 1'b0, eop: 1'b0, data: avg_model(mem0[i], mem1[i])});
    if (model_pair == HH - 2) begin
      for (int l = 0; l < 2; l++)
        for (int i = 0; i < W; i++)
          exp_q.push_back('{sop: 1'b0, eop: (l == 1 && i == W - 1), data: line_word(nb, i)});
    end
  endtask

  task automatic fill_const(input logic [DW-1:0] a, input logic [DW-1:0] b);
    for (int i = 0; i < W; i++) begin
      mem0[i] = a;
      mem1[i] = b;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < W; i++) begin
      mem0[i] = DW'($urandom);
      mem1[i] = DW'($urandom);
    end
  endtask

  task automatic run_pair(input bit rand_ready, input string tag);
    int            cycles   = 0;
    int            aver_cnt = 0;
    int            gaps     = 0;
    int            idx      = 0;
    bit            started  = 0;
    bit            stall_prev = 0;
    logic [DW-1:0] prev_data = '0;
    word_t         exp_w;
    build_expected();
    @(posedge clock); #1;
    ready_to_continue = 1'b1;
    while ((exp_q.size() > 0 || aver_cnt == 0) && cycles < 2000) begin
      dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clock);
      cycles++;
      if (aver_sent) begin
        aver_cnt++;
        ready_to_continue = 1'b0;
      end
      if (stall_prev) begin
        check({tag, "_hold_valid"}, 64'(dout_valid), 64'd1);
        check({tag, "_hold_data"}, 64'(dout_data), 64'(prev_data));
      end
      if (dout_valid && dout_ready) begin
        // An unexpected extra word is compared against an impossible sop+eop word.
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : '{sop: 1'b1, eop: 1'b1, data: '1};
        check($sformatf("%s_word%0d", tag, idx), 64'({dout_sop, dout_eop, dout_data}), 64'(exp_w));
        idx++;
        started = 1;
      end else if (started && exp_q.size() > 0 && !dout_valid) begin
        gaps++;
      end
      stall_prev = dout_valid && !dout_ready;
      prev_data  = dout_data;
      @(posedge clock); #1;
    end
    check({tag, "_in_time"}, 64'(cycles < 2000), 64'd1);
    check({tag, "_aver_once"}, 64'(aver_cnt), 64'd1);
    if (!rand_ready) check({tag, "_no_gaps"}, 64'(gaps), 64'd0);
    repeat (3) @(negedge clock);
    check({tag, "_no_extra"}, 64'(dout_valid), 64'd0);
    model_ob   = 1 - model_ob;
    model_pair = (model_pair == HH - 2) ? 0 : model_pair + 1;
  endtask

  initial begin
    int got;
    int cyc;
    int abort_aver;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      check("reset_idle", 64'({aver_sent, rd_en0, rd_en1, dout_valid, dout_sop, dout_eop, dout_data, rd_addr}), 64'd0);
    end

    fill_const(24'h101010, 24'h303030);
    run_pair(1'b0, "pair1");
    fill_rand();
    run_pair(1'b0, "final_pair");

    fill_const(24'hFF01FF, 24'hFF00FE);
    run_pair(1'b0, "overflow");
    fill_rand();
    run_pair(1'b1, "rand_final");

    fill_const(24'h101010, 24'h303030);
    run_pair(1'b1, "toggle_ready");
    fill_rand();
    run_pair(1'b1, "toggle_final");

    // Reset while the averaged line is being read.
    fill_rand();
    got = 0;
    cyc = 0;
    abort_aver = 0;
    @(posedge clock); #1;
    dout_ready = 1'b1;
    ready_to_continue = 1'b1;
    while (got < 5 && cyc < 200) begin
      @(negedge clock);
      cyc++;
      if (aver_sent) abort_aver++;
      if (dout_valid && dout_ready) got++;
      @(posedge clock); #1;
    end
    check("abort_reached", 64'(got), 64'd5);
    reset = 1'b1;
    ready_to_continue = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("abort_outputs", 64'({aver_sent, rd_en0, rd_en1, dout_valid, dout_sop, dout_eop, dout_data, rd_addr}), 64'd0);
    repeat (5) begin
      @(negedge clock);
      if (aver_sent) abort_aver++;
    end
    check("abort_no_aver", 64'(abort_aver), 64'd0);
    model_ob   = 0;
    model_pair = 0;

    fill_rand();
    run_pair(1'b1, "after_reset");
    fill_rand();
    run_pair(1'b0, "after_reset_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
